// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ event path.
// Holds the word-type nibbles (bits [15:12] of a readout word), the event
// buffer state encoding and a saturating increment helper. The soft TBM
// header/trailer generator uses the same nibble constants.
package daq_pkg;

    localparam logic [3:0] WT_HDR1 = 4'hA;  // event header, opens an event
    localparam logic [3:0] WT_HDR2 = 4'h8;  // second header word (body here)
    localparam logic [3:0] WT_TRL1 = 4'hE;  // first trailer word (body here)
    localparam logic [3:0] WT_TRL2 = 4'hC;  // final trailer, closes an event

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DROP = 2'd2
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/daq_buf_ram.sv
// Simple dual-port RAM, 2^AW x 16, for the event buffer.
// Ports:
//   clk          clock for both ports
//   we/waddr/wdata  synchronous write port
//   re/raddr     read enable and address; q updates only when re is high,
//                so q holds its value while the reader is stalled
//   q            registered read data
module daq_buf_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   q
);

    logic [15:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            q <= mem[raddr];
        end
    end

endmodule

// File: rtl/daq_event_buffer.sv
// Event buffer between the soft TBM readout word stream and the DAQ memory
// writer. Header (A) .. trailer (C) framed events are written into a circular
// buffer and become readable only once their C word has been written, so the
// sink never sees a partial event. Overflowing or badly framed events are
// rolled back and counted.
//
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   clear              synchronous flush of pointers, counters and state
//   enable             accept input words when high; falling mid-event drops it
//   daq_write/daq_data input word strobe and word
//   dout/dout_valid/dout_ready/dout_last  output word stream
//   level              committed words not yet transferred (incl. held word)
//   event_count        committed events (wrapping)
//   drop_count         discarded events (saturating)
//   orphan_count       words seen outside an event (saturating)
//   state              write-side state, for observation
//
// Output handshake: a word transfers on a clock edge where dout_valid and
// dout_ready are both high. While dout_valid is high and dout_ready is low,
// dout and dout_last stay unchanged. dout_valid never depends on dout_ready
// in the same cycle.
module daq_event_buffer
    import daq_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    input  logic          daq_write,
    input  logic [15:0]   daq_data,
    output logic [15:0]   dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_last,
    output logic [AW-1:0] level,
    output logic [15:0]   event_count,
    output logic [15:0]   drop_count,
    output logic [15:0]   orphan_count,
    output state_t        state
);

    localparam logic [AW-1:0] ONE = AW'(1);

    logic [AW-1:0] wr_ptr, ev_start, commit_ptr, rd_ptr;
    // commit_ptr delayed by one clock. The RAM write port is registered, so
    // the last word of an event lands one edge after the commit; the reader
    // only looks at this delayed copy and therefore never reads a slot in
    // the same cycle it is written.
    logic [AW-1:0] commit_vis;
    logic [AW-1:0] wr_next, ev_next, rd_next;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [15:0]   mem_wdata;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [15:0]   ram_q;

    logic accept, full, is_hdr, is_trl, xfer;

    assign wr_next = wr_ptr + ONE;
    assign ev_next = ev_start + ONE;
    assign rd_next = rd_ptr + ONE;

    assign accept = daq_write && enable && !clear;
    assign is_hdr = (daq_data[15:12] == WT_HDR1);
    assign is_trl = (daq_data[15:12] == WT_TRL2);
    // rd_ptr is the held (or next-to-fetch) word, so the slot under the
    // output register is protected as well.
    assign full   = (wr_next == rd_ptr);

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            ev_start     <= '0;
            commit_ptr   <= '0;
            commit_vis   <= '0;
            event_count  <= '0;
            drop_count   <= '0;
            orphan_count <= '0;
            mem_we       <= 1'b0;
            mem_waddr    <= '0;
            mem_wdata    <= '0;
        end else begin
            mem_we     <= 1'b0;
            commit_vis <= commit_ptr;
            if (clear) begin
                state        <= IDLE;
                wr_ptr       <= '0;
                ev_start     <= '0;
                commit_ptr   <= '0;
                commit_vis   <= '0;
                event_count  <= '0;
                drop_count   <= '0;
                orphan_count <= '0;
            end else begin
                case (state)
                    IDLE, DROP: begin
                        if (accept) begin
                            if (is_hdr) begin
                                if (full) begin
                                    drop_count <= sat_inc(drop_count);
                                    state      <= DROP;
                                end else begin
                                    mem_we    <= 1'b1;
                                    mem_waddr <= wr_ptr;
                                    mem_wdata <= daq_data;
                                    ev_start  <= wr_ptr;
                                    wr_ptr    <= wr_next;
                                    state     <= FILL;
                                end
                            end else if (state == IDLE) begin
                                orphan_count <= sat_inc(orphan_count);
                            end else if (is_trl) begin
                                state <= IDLE;
                            end
                        end
                    end
                    FILL: begin
                        if (!enable) begin
                            wr_ptr     <= ev_start;
                            drop_count <= sat_inc(drop_count);
                            state      <= IDLE;
                        end else if (accept) begin
                            if (is_hdr) begin
                                // Abandon the open event and restart it in
                                // place with this header.
                                mem_we     <= 1'b1;
                                mem_waddr  <= ev_start;
                                mem_wdata  <= daq_data;
                                wr_ptr     <= ev_next;
                                drop_count <= sat_inc(drop_count);
                            end else if (full) begin
                                wr_ptr     <= ev_start;
                                drop_count <= sat_inc(drop_count);
                                state      <= DROP;
                            end else begin
                                mem_we    <= 1'b1;
                                mem_waddr <= wr_ptr;
                                mem_wdata <= daq_data;
                                wr_ptr    <= wr_next;
                                if (is_trl) begin
                                    commit_ptr  <= wr_next;
                                    event_count <= event_count + 16'd1;
                                    state       <= IDLE;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side: one prefetched word sits in the RAM output register.
    // ------------------------------------------------------------------
    assign xfer    = dout_valid && dout_ready;
    assign rd_addr = xfer ? rd_next : rd_ptr;
    assign rd_en   = !clear && (xfer ? (rd_next != commit_vis)
                                     : (!dout_valid && (rd_ptr != commit_vis)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            dout_valid <= 1'b0;
        end else if (clear) begin
            rd_ptr     <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (xfer) begin
                rd_ptr <= rd_next;
            end
            dout_valid <= rd_en || (dout_valid && !dout_ready);
        end
    end

    daq_buf_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (rd_en),
        .raddr (rd_addr),
        .q     (ram_q)
    );

    // The RAM register is not reset, so the word is gated by dout_valid.
    assign dout      = dout_valid ? ram_q : 16'h0000;
    assign dout_last = dout_valid && (ram_q[15:12] == WT_TRL2);
    assign level     = commit_ptr - rd_ptr;

endmodule

// File: tb/tb_daq_event_buffer.sv
// Bench for daq_event_buffer with a 16-word buffer (15 usable).
module tb_daq_event_buffer;
  import daq_pkg::*;

  localparam int AW  = 4;
  localparam int CAP = (1 << AW) - 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset, clear, enable, daq_write, dout_ready;
  logic [15:0]   daq_data;
  logic [15:0]   dout;
  logic          dout_valid, dout_last;
  logic [AW-1:0] level;
  logic [15:0]   event_count, drop_count, orphan_count;
  state_t        st;
  logic          toggle_on = 1'b0;

  always #5 clk = ~clk;

  daq_event_buffer #(.AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .enable       (enable),
    .daq_write    (daq_write),
    .daq_data     (daq_data),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .dout_last    (dout_last),
    .level        (level),
    .event_count  (event_count),
    .drop_count   (drop_count),
    .orphan_count (orphan_count),
    .state        (st)
  );

  // ---------------- scoreboard / model ----------------
  logic [15:0] exp_q[$];   // committed, untransferred words
  logic [15:0] cur_q[$];   // words of the open event
  logic [15:0] out_log[$]; // words actually transferred
  state_t      m_state;
  logic [15:0] m_ev, m_drop, m_orph;
  logic        prev_stall;
  logic [15:0] prev_dout;
  int          checks = 0;
  int          errors = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    cur_q.delete();
    m_state = IDLE;
    m_ev = 0;
    m_drop = 0;
    m_orph = 0;
  endfunction

  // Advance the model across the coming rising edge using the current inputs.
  function automatic void model_step();
    logic        full;
    logic [15:0] w;
    logic [3:0]  t;
    if (clear) begin
      model_reset();
      return;
    end
    full = ((exp_q.size() + cur_q.size()) == CAP);
    if (dout_valid && dout_ready && exp_q.size() > 0) begin
      out_log.push_back(dout);
      void'(exp_q.pop_front());
    end
    w = daq_data;
    t = w[15:12];
    case (m_state)
      IDLE, DROP: begin
        if (daq_write && enable) begin
          if (t == 4'hA) begin
            if (full) begin
              m_drop = sat16(m_drop);
              m_state = DROP;
            end else begin
              cur_q.delete();
              cur_q.push_back(w);
              m_state = FILL;
            end
          end else if (m_state == IDLE) begin
            m_orph = sat16(m_orph);
          end else if (t == 4'hC) begin
            m_state = IDLE;
          end
        end
      end
      FILL: begin
        if (!enable) begin
          cur_q.delete();
          m_drop = sat16(m_drop);
          m_state = IDLE;
        end else if (daq_write) begin
          if (t == 4'hA) begin
            cur_q.delete();
            cur_q.push_back(w);
            m_drop = sat16(m_drop);
          end else if (full) begin
            cur_q.delete();
            m_drop = sat16(m_drop);
            m_state = DROP;
          end else begin
            cur_q.push_back(w);
            if (t == 4'hC) begin
              foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
              cur_q.delete();
              m_ev = m_ev + 16'd1;
              m_state = IDLE;
            end
          end
        end
      end
      default: m_state = IDLE;
    endcase
  endfunction

  // Compare process: outputs vs model every falling edge, then step model.
  always @(negedge clk) begin
    logic [15:0] head;
    logic        head_last;
    if (!reset) begin
      model_reset();
      prev_stall = 1'b0;
    end
    check("level", 32'(level), 32'(exp_q.size()));
    check("event_count", 32'(event_count), 32'(m_ev));
    check("drop_count", 32'(drop_count), 32'(m_drop));
    check("orphan_count", 32'(orphan_count), 32'(m_orph));
    check("state", 32'(st), 32'(m_state));
    if (dout_valid) begin
      if (exp_q.size() == 0) begin
        check("valid_without_data", 32'(dout_valid), 32'd0);
      end else begin
        head = exp_q[0];
        head_last = (head[15:12] == 4'hC);
        check("dout", 32'(dout), 32'(head));
        check("dout_last", 32'(dout_last), 32'(head_last));
      end
    end
    if (prev_stall) begin
      check("stall_valid", 32'(dout_valid), 32'd1);
      check("stall_dout", 32'(dout), 32'(prev_dout));
    end
    prev_stall = reset && !clear && dout_valid && !dout_ready;
    prev_dout = dout;
    if (reset) model_step();
  end

  always @(posedge clk) begin
    if (toggle_on) begin
      #1;
      dout_ready = ~dout_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic put(input logic [15:0] w);
    daq_write = 1'b1;
    daq_data = w;
    @(posedge clk);
    #1;
    daq_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    out_log.delete();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || dout_valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_log(input string name, input logic [15:0] w0,
                           input logic [15:0] w1, input logic [15:0] w2,
                           input logic [15:0] w3);
    logic [15:0] ref_w[4];
    ref_w[0] = w0; ref_w[1] = w1; ref_w[2] = w2; ref_w[3] = w3;
    check({name, "_count"}, 32'(out_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check(name, 32'(out_log[i]), 32'(ref_w[i]));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    clear = 1'b0;
    enable = 1'b1;
    daq_write = 1'b0;
    daq_data = 16'h0000;
    dout_ready = 1'b1;
    model_reset();
    idle(2);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_last", 32'(dout_last), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    reset = 1'b1;
    idle(1);

    // 1: basic event, latency and order
    put(16'hA005); put(16'h8003); put(16'hE000); put(16'hC001);
    @(negedge clk); check("lat_edge_n", 32'(dout_valid), 32'd0);
    @(negedge clk); check("lat_edge_n1", 32'(dout_valid), 32'd0);
    @(negedge clk); check("lat_edge_n2", 32'(dout_valid), 32'd1);
    check("first_word", 32'(dout), 32'hA005);
    drain(20);
    check_log("t1_words", 16'hA005, 16'h8003, 16'hE000, 16'hC001);
    check("t1_events", 32'(event_count), 32'd1);
    check("t1_level", 32'(level), 32'd0);

    // 2: partial event stays invisible
    do_clear();
    put(16'hA005); put(16'h8003); put(16'hE000);
    idle(4);
    check("t2_level", 32'(level), 32'd0);
    check("t2_valid", 32'(dout_valid), 32'd0);
    put(16'hC001);
    drain(20);
    check_log("t2_words", 16'hA005, 16'h8003, 16'hE000, 16'hC001);

    // 3: overflow rollback with stalled sink
    do_clear();
    dout_ready = 1'b0;
    put(16'hA100);
    for (int i = 0; i < 18; i++) put(16'h8000 + 16'(i));
    put(16'hC0FF);
    idle(3);
    check("t3_level", 32'(level), 32'd0);
    check("t3_drop", 32'(drop_count), 32'd1);
    check("t3_events", 32'(event_count), 32'd0);
    check("t3_state", 32'(st), 32'(IDLE));
    put(16'hA200); put(16'h8201); put(16'hE202); put(16'hC203);
    idle(3);
    check("t3_level4", 32'(level), 32'd4);
    check("t3_held", 32'(dout), 32'hA200);
    dout_ready = 1'b1;
    drain(20);
    check_log("t3_words", 16'hA200, 16'h8201, 16'hE202, 16'hC203);

    // 4: orphan word
    do_clear();
    put(16'hE000);
    idle(1);
    check("t4_orphan", 32'(orphan_count), 32'd1);
    check("t4_state", 32'(st), 32'(IDLE));
    check("t4_level", 32'(level), 32'd0);

    // 5: header inside an event restarts it
    do_clear();
    put(16'hA001); put(16'h8000); put(16'hA002); put(16'h8000);
    put(16'hE000); put(16'hC000);
    drain(20);
    check("t5_drop", 32'(drop_count), 32'd1);
    check_log("t5_words", 16'hA002, 16'h8000, 16'hE000, 16'hC000);

    // 6: toggling sink, reset mid-second-event
    do_clear();
    toggle_on = 1'b1;
    put(16'hA011); put(16'h8012); put(16'hE013); put(16'hC014);
    put(16'hA021); put(16'h8022);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("t6_dout", 32'(dout), 32'd0);
    check("t6_valid", 32'(dout_valid), 32'd0);
    check("t6_last", 32'(dout_last), 32'd0);
    check("t6_level", 32'(level), 32'd0);
    check("t6_events", 32'(event_count), 32'd0);
    check("t6_drop", 32'(drop_count), 32'd0);
    check("t6_orphan", 32'(orphan_count), 32'd0);
    reset = 1'b1;
    out_log.delete();
    put(16'hA031); put(16'h8032); put(16'hE033); put(16'hC034);
    drain(100);
    check_log("t6_words", 16'hA031, 16'h8032, 16'hE033, 16'hC034);
    toggle_on = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/daq_event_buffer.md
Name: daq_event_buffer

Overview:
- Downstream consumer of the soft TBM readout word stream (daq_write / daq_data).
- Stores header/trailer-framed events in a circular buffer. An event becomes readable only once its final trailer word (nibble C) is written, so the DAQ sink never sees a partial event.
- Events that overflow the buffer or are framed incorrectly are rolled back and counted.
- Output is a valid/ready word stream toward the DAQ memory writer.

Parameters:
- AW, 10, buffer address width. Depth is 2^AW words; usable capacity is 2^AW-1 (one slot is always kept empty).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- clear  in  1  synchronous flush of pointers, counters and state; takes priority over all other inputs
- enable  in  1  accept input words when 1
- daq_write  in  1  input word strobe (already sync-qualified upstream)
- daq_data  in  16  input word
- dout  out  16  output word
- dout_valid  out  1  dout holds a committed word
- dout_ready  in  1  sink accepts dout
- dout_last  out  1  dout is the event's last word (dout[15:12]==4'hC)
- level  out  AW  committed, unread words (commit_ptr - rd_ptr)
- event_count  out  16  committed events, wraps at 16 bits
- drop_count  out  16  discarded events, saturating
- orphan_count  out  16  words received outside an event, saturating

Behaviour:
- Reset or clear: all pointers (wr_ptr, ev_start, commit_ptr, rd_ptr) = 0, state = IDLE, all counters = 0. On reset, dout = 0, dout_valid = 0, dout_last = 0. On clear, dout_valid = 0 in the next cycle.
- A word is accepted when daq_write && enable && !clear. Word type is taken from daq_data[15:12]: A = header, C = final trailer, anything else = body.
- Full: wr_ptr+1 == rd_ptr (modulo 2^AW).
- IDLE:
  - Header: store it, ev_start = wr_ptr, wr_ptr++, go to FILL.
  - Any other word: discard it, orphan_count++.
- FILL:
  - Body or C word, not full: store it, wr_ptr++.
  - C word: commit_ptr = new wr_ptr in the same edge, event_count++, go to IDLE.
  - Header: roll back wr_ptr = ev_start, drop_count++, then treat the header as the start of a new event in the same cycle (ev_start = ev_start, store, wr_ptr = ev_start+1). State stays FILL.
  - Full on any accepted word: wr_ptr = ev_start, drop_count++, go to DROP. The word is not stored.
  - enable falls: roll back wr_ptr = ev_start, drop_count++, go to IDLE.
- DROP:
  - Discard all words until a header. A C word returns to IDLE with no count.
  - Header: behaves as in IDLE (checked against full; if full, stay in DROP and drop_count++).
- Read side:
  - Registered RAM read. dout_valid = 1 when a prefetched word is held.
  - A word transfers on dout_valid && dout_ready, then the next word is prefetched. With continuous ready, throughput is 1 word/clk.
  - dout and dout_last are held stable while dout_valid && !dout_ready.
  - Prefetch reads only addresses strictly before commit_ptr.
  - Latency: C word accepted at edge N -> dout_valid high at edge N+2 at the earliest (buffer previously empty).
- level counts committed words not yet transferred, including the prefetched word.
- Reads and writes in the same cycle are independent. rd_ptr only advances inside the committed region, so rollback never touches readable data.
- Pointers are AW bits and wrap naturally. Arithmetic is modulo 2^AW.
- Saturating counters hold at 16'hFFFF.
- Reset asserted mid-event discards everything, including committed-but-unread words.

Decomposition:
- Shared package daq_pkg:
  - Nibble constants WT_HDR1=4'hA, WT_HDR2=4'h8, WT_TRL1=4'hE, WT_TRL2=4'hC.
  - State encoding IDLE/FILL/DROP.
  - Shared with soft TBM header/trailer generation.
- Sub-module daq_buf_ram: simple dual-port RAM, 2^AW x 16, one write port and one registered read port with read enable. Inferable block RAM.

Test Plan (AW=4, usable 15 words):
- Event A005, 8003, E000, C001 with dout_ready=1 -> dout_valid from 2 clks after C001; words appear in order; dout_last=1 only on C001; event_count=1; level returns to 0.
- Stop after A005, 8003, E000 -> dout_valid stays 0 and level=0; send C001 -> 4 words delivered.
- dout_ready=0, event of header + 18 body words + C word -> rollback occurs, level=0, drop_count=1, trailer ignored. Then a 4-word event is committed with level=4.
- E000 in IDLE -> no store, orphan_count=1, state stays IDLE.
- A001, 8000, then A002, 8000, E000, C000 -> drop_count=1; output is exactly A002, 8000, E000, C000.
- Three 4-word events with dout_ready toggling 1/0 every clk, reset pulled low mid-second-event -> dout held stable while stalled. After reset, all outputs and counters are 0 and the next event is delivered intact.
